nonce_queue: RTL

Collects golden nonces from all local hashcores and external slave receivers and queues them for the UART transmitter, in a single clock domain. It sits between the per-slave `slave_nonces`/`new_nonces` buses and `serial_transmit`. It captures every match pulse and arbitrates slaves round-robin into a FIFO. It then drives the `send`/`busy` handshake one word at a time. Lost results are counted rather than silently discarded.

---
 rtl/nonce_queue_defs.sv | 21 ++
 rtl/nonce_fifo.sv | 70 +++++++
 rtl/nonce_queue.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nonce_queue_defs.sv
// Shared definitions for the nonce queue: word width, TX FSM encoding and the
// transmitter busy timeout.
package nonce_queue_defs;

  localparam int unsigned NONCE_W      = 32;
  localparam int unsigned BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2
  } tx_state_e;

  // Add up to 16 new drops to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with first-word fall-through head. Storage is a plain register
// array without reset so it maps onto distributed RAM.
module nonce_fifo
  import nonce_queue_defs::*;
#(
  parameter int unsigned Width = NONCE_W,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nonce_queue.sv
// Collects golden nonces from all slaves, arbitrates them round-robin into a FIFO
// and feeds the serial transmitter one word per send/busy handshake.
module nonce_queue
  import nonce_queue_defs::*;
#(
  parameter int unsigned SLAVES     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
  input  logic [SLAVES-1:0]           new_nonces,
  input  logic                        serial_busy,
  output logic                        serial_send,
  output logic [NONCE_W-1:0]          golden_nonce,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count
);

  localparam int unsigned IdxW   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int unsigned TimerW = $clog2(BUSY_TIMEOUT + 1);

  // Edge detect and pending slots
  logic [SLAVES-1:0]  prev_q;
  logic [SLAVES-1:0]  rise;
  logic [SLAVES-1:0]  pend_valid_q, pend_valid_d;
  logic [NONCE_W-1:0] pend_data_q [SLAVES];
  logic [NONCE_W-1:0] pend_data_d [SLAVES];
  logic [4:0]         drops;
  logic [7:0]         drop_count_q, drop_count_d;

  // Arbiter
  logic [IdxW-1:0]    last_grant_q, last_grant_d;
  logic [IdxW-1:0]    grant_idx;
  logic               grant_valid;

  // FIFO
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [NONCE_W-1:0] fifo_rdata;

  // TX FSM
  tx_state_e          state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               send_q, send_d;
  logic [NONCE_W-1:0] golden_q, golden_d;

  assign rise = new_nonces & ~prev_q;

  // Round-robin pick of one pending slot, starting after the last winner.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    if (!fifo_full) begin
      for (int unsigned k = 1; k <= SLAVES; k++) begin
        cand = (32'(last_grant_q) + k) % SLAVES;
        if (!grant_valid && pend_valid_q[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IdxW'(cand);
        end
      end
    end
    last_grant_d = grant_valid ? grant_idx : last_grant_q;
  end

  // Pending slot update: capture on rise, drop on collision unless the slot drains now.
  always_comb begin
    logic drain;
    drain        = 1'b0;
    drops        = '0;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    for (int i = 0; i < int'(SLAVES); i++) begin
      drain = grant_valid && (grant_idx == IdxW'(i));
      if (rise[i]) begin
        if (pend_valid_q[i] && !drain) begin
          drops = drops + 5'd1;
        end else begin
          pend_valid_d[i] = 1'b1;
          pend_data_d[i]  = slave_nonces[i*NONCE_W +: NONCE_W];
        end
      end else if (drain) begin
        pend_valid_d[i] = 1'b0;
      end
    end
    drop_count_d = sat_add_u8(drop_count_q, drops);
  end

  // Edge detect, pending slots, arbiter pointer and drop counter registers.
  // Edge history loads the live strobes in reset so a held-high strobe is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= new_nonces;
      pend_valid_q <= '0;
      last_grant_q <= IdxW'(SLAVES - 1);
      drop_count_q <= '0;
      for (int i = 0; i < int'(SLAVES); i++) pend_data_q[i] <= '0;
    end else begin
      prev_q       <= new_nonces;
      pend_valid_q <= pend_valid_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
      pend_data_q  <= pend_data_d;
    end
  end

  nonce_fifo #(
    .Width (NONCE_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (grant_valid),
    .wdata_i (pend_data_q[grant_idx]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // TX FSM next-state: send from IDLE, then wait for busy to rise (with timeout) and fall.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    send_d   = 1'b0;
    golden_d = golden_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty && !serial_busy) begin
          fifo_pop = 1'b1;
          golden_d = fifo_rdata;
          send_d   = 1'b1;
          timer_d  = '0;
          state_d  = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (serial_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerW'(BUSY_TIMEOUT)) begin
          // Transmitter never acknowledged; treat the word as sent.
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (!serial_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // TX FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      send_q   <= 1'b0;
      golden_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      send_q   <= send_d;
      golden_q <= golden_d;
    end
  end

  assign serial_send  = send_q;
  assign golden_nonce = golden_q;
  assign drop_count   = drop_count_q;

endmodule
